// File: rtl/arrow_sprite_engine_pkg.sv
// Shared types and helpers for the multi-sprite arrow overlay.
package arrow_sprite_engine_pkg;

    // Direction codes: the arrow tip points in this direction from the base centre.
    typedef enum logic [1:0] {
        DIR_EAST  = 2'd0,
        DIR_WEST  = 2'd1,
        DIR_NORTH = 2'd2,
        DIR_SOUTH = 2'd3
    } dir_e;

    localparam int ARROW_SIZE_DEFAULT = 8;

    // Slot index width, never below one bit so a single-sprite build still has a port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arrow_sprite_engine_if.sv
// Sprite update bus: one write per cycle into the pending slot table.
interface arrow_sprite_engine_if
    import arrow_sprite_engine_pkg::*;
#(
    parameter int N_SPRITES = 4,
    parameter int COORD_W   = 11
);
    localparam int IDX_W = idx_width(N_SPRITES);

    logic               upd_we;
    logic [IDX_W-1:0]   upd_idx;
    logic [COORD_W-1:0] upd_px;
    logic [COORD_W-1:0] upd_py;
    dir_e               upd_dir;
    logic               upd_en;
    logic               upd_blink;

    modport master (
        output upd_we, upd_idx, upd_px, upd_py, upd_dir, upd_en, upd_blink
    );

    modport slave (
        input upd_we, upd_idx, upd_px, upd_py, upd_dir, upd_en, upd_blink
    );

endinterface

// File: rtl/arrow_sprite_engine_hit.sv
// Per-sprite hit test: first stage rotates the pixel offset into the arrow's frame,
// second stage (combinational from the registered values) tests the triangle.
module arrow_hit_unit
    import arrow_sprite_engine_pkg::*;
#(
    parameter int COORD_W    = 11,
    parameter int ARROW_SIZE = ARROW_SIZE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  dir_e               dir,
    input  logic               vis,
    output logic               hit
);

    localparam logic signed [COORD_W:0] SIZE_S = (COORD_W+1)'(ARROW_SIZE);

    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic signed [COORD_W:0] fwd_d;
    logic signed [COORD_W:0] side_d;
    logic signed [COORD_W:0] fwd_q;
    logic signed [COORD_W:0] side_q;
    logic signed [COORD_W:0] limit;
    logic                    vis_q;

    // One extra bit keeps the offset from wrapping for any pair of screen coordinates.
    assign dx = $signed({1'b0, x}) - $signed({1'b0, px});
    assign dy = $signed({1'b0, y}) - $signed({1'b0, py});

    // Rotate the offset so "fwd" runs from base toward tip and "side" across the base.
    always_comb begin
        fwd_d  = dx;
        side_d = dy;
        case (dir)
            DIR_EAST:  begin fwd_d = dx;  side_d = dy; end
            DIR_WEST:  begin fwd_d = -dx; side_d = dy; end
            DIR_NORTH: begin fwd_d = -dy; side_d = dx; end
            DIR_SOUTH: begin fwd_d = dy;  side_d = dx; end
            default:   begin fwd_d = dx;  side_d = dy; end
        endcase
    end

    // First pipeline stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q  <= '0;
            side_q <= '0;
            vis_q  <= 1'b0;
        end else begin
            fwd_q  <= fwd_d;
            side_q <= side_d;
            vis_q  <= vis;
        end
    end

    // Half-width of the triangle shrinks by one pixel per pixel of forward travel.
    assign limit = SIZE_S - fwd_q;
    assign hit   = vis_q & ~fwd_q[COORD_W] & (fwd_q <= SIZE_S)
                 & (side_q <= limit) & (side_q >= -limit);

endmodule

// File: rtl/arrow_sprite_engine.sv
// Multi-sprite arrow overlay: double-buffered slot table, blink frame counter,
// per-sprite hit units and a lowest-index priority encoder, latency 2.
module arrow_sprite_engine
    import arrow_sprite_engine_pkg::*;
#(
    parameter int  N_SPRITES  = 4,
    parameter int  ARROW_SIZE = ARROW_SIZE_DEFAULT,
    parameter int  COORD_W    = 11,
    parameter int  BLINK_LOG2 = 5,
    localparam int IDX_W      = idx_width(N_SPRITES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  de_in,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    arrow_sprite_engine_if.slave  upd,
    output logic                  de_out,
    output logic                  pixel_on,
    output logic [IDX_W-1:0]      sprite_id
);

    typedef struct packed {
        logic [COORD_W-1:0] px;
        logic [COORD_W-1:0] py;
        dir_e               dir;
        logic               en;
        logic               blink;
    } slot_t;

    slot_t                 pending [N_SPRITES];
    slot_t                 active  [N_SPRITES];
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic [N_SPRITES-1:0]  vis;
    logic [N_SPRITES-1:0]  hit;
    logic                  de_s1;
    logic [IDX_W-1:0]      hit_id;

    // Pending table: CPU-side writes; indices past the last slot match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPRITES; i++) pending[i] <= '0;
        end else if (upd.upd_we) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (upd.upd_idx == IDX_W'(i)) begin
                    pending[i].px    <= upd.upd_px;
                    pending[i].py    <= upd.upd_py;
                    pending[i].dir   <= upd.upd_dir;
                    pending[i].en    <= upd.upd_en;
                    pending[i].blink <= upd.upd_blink;
                end
            end
        end
    end

    // Active table and blink counter advance together at the start of vblank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPRITES; i++) active[i] <= '0;
            frame_cnt <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < N_SPRITES; i++) active[i] <= pending[i];
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Blinking slots are suppressed during the upper half of the frame-counter period.
    always_comb begin
        vis = '0;
        for (int i = 0; i < N_SPRITES; i++)
            vis[i] = active[i].en & ~(active[i].blink & frame_cnt[BLINK_LOG2-1]);
    end

    for (genvar i = 0; i < N_SPRITES; i++) begin : g_hit
        arrow_hit_unit #(
            .COORD_W    (COORD_W),
            .ARROW_SIZE (ARROW_SIZE)
        ) u_hit (
            .clk   (clk),
            .rst_n (rst_n),
            .x     (x),
            .y     (y),
            .px    (active[i].px),
            .py    (active[i].py),
            .dir   (active[i].dir),
            .vis   (vis[i]),
            .hit   (hit[i])
        );
    end

    // Lowest-index covering slot wins; scanning downward leaves the smallest one.
    always_comb begin
        hit_id = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--)
            if (hit[i]) hit_id = IDX_W'(i);
    end

    // Display-enable delay and registered outputs of the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1     <= 1'b0;
            de_out    <= 1'b0;
            pixel_on  <= 1'b0;
            sprite_id <= '0;
        end else begin
            de_s1     <= de_in;
            de_out    <= de_s1;
            pixel_on  <= de_s1 & (|hit);
            sprite_id <= (de_s1 & (|hit)) ? hit_id : '0;
        end
    end

endmodule

// File: tb/tb_arrow_sprite_engine.sv
// Directed bench for arrow_sprite_engine: shape, double buffering, priority,
// blink, display-enable gating, out-of-range writes, streaming and reset.
module tb_arrow_sprite_engine;
    import arrow_sprite_engine_pkg::*;

    localparam int CW = 11;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic          de_in;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de_out;
    logic          pixel_on;
    logic [1:0]    sprite_id;
    logic          de_out3;
    logic          pixel_on3;
    logic [1:0]    sprite_id3;

    int checks = 0;
    int errors = 0;

    arrow_sprite_engine_if #(.N_SPRITES(4), .COORD_W(CW)) upd_if ();
    arrow_sprite_engine_if #(.N_SPRITES(3), .COORD_W(CW)) upd3_if ();

    arrow_sprite_engine #(
        .N_SPRITES(4), .ARROW_SIZE(8), .COORD_W(CW), .BLINK_LOG2(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .de_in(de_in),
        .x(x), .y(y), .upd(upd_if.slave),
        .de_out(de_out), .pixel_on(pixel_on), .sprite_id(sprite_id)
    );

    arrow_sprite_engine #(
        .N_SPRITES(3), .ARROW_SIZE(8), .COORD_W(CW), .BLINK_LOG2(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .de_in(de_in),
        .x(x), .y(y), .upd(upd3_if.slave),
        .de_out(de_out3), .pixel_on(pixel_on3), .sprite_id(sprite_id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int px, input int py, input logic de);
        x     = CW'(px);
        y     = CW'(py);
        de_in = de;
    endtask

    task automatic checkOutput(input string tag,
                               input logic obs_on, input logic [1:0] obs_id, input logic obs_de,
                               input logic exp_on, input logic [1:0] exp_id, input logic exp_de);
        checks++;
        assert (obs_on === exp_on) else begin
            errors++;
            $error("[TB] FAIL %s pixel_on observed=%0b expected=%0b", tag, obs_on, exp_on);
        end
        checks++;
        assert (obs_id === exp_id) else begin
            errors++;
            $error("[TB] FAIL %s sprite_id observed=%0d expected=%0d", tag, obs_id, exp_id);
        end
        checks++;
        assert (obs_de === exp_de) else begin
            errors++;
            $error("[TB] FAIL %s de_out observed=%0b expected=%0b", tag, obs_de, exp_de);
        end
    endtask

    task automatic probe(input string tag, input int px, input int py,
                         input logic exp_on, input logic [1:0] exp_id);
        applyStimulus(px, py, 1'b1);
        tick();
        tick();
        checkOutput(tag, pixel_on, sprite_id, de_out, exp_on, exp_id, 1'b1);
    endtask

    task automatic probe3(input string tag, input int px, input int py,
                          input logic exp_on, input logic [1:0] exp_id);
        applyStimulus(px, py, 1'b1);
        tick();
        tick();
        checkOutput(tag, pixel_on3, sprite_id3, de_out3, exp_on, exp_id, 1'b1);
    endtask

    task automatic writeSlot(input int idx, input int px, input int py,
                             input dir_e dir, input logic en, input logic blink);
        upd_if.upd_we    = 1'b1;
        upd_if.upd_idx   = 2'(idx);
        upd_if.upd_px    = CW'(px);
        upd_if.upd_py    = CW'(py);
        upd_if.upd_dir   = dir;
        upd_if.upd_en    = en;
        upd_if.upd_blink = blink;
        tick();
        upd_if.upd_we    = 1'b0;
    endtask

    task automatic writeSlot3(input int idx, input int px, input int py,
                              input dir_e dir, input logic en);
        upd3_if.upd_we    = 1'b1;
        upd3_if.upd_idx   = 2'(idx);
        upd3_if.upd_px    = CW'(px);
        upd3_if.upd_py    = CW'(py);
        upd3_if.upd_dir   = dir;
        upd3_if.upd_en    = en;
        upd3_if.upd_blink = 1'b0;
        tick();
        upd3_if.upd_we    = 1'b0;
    endtask

    task automatic frameStart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    int sx [6] = '{301, 309, 600, 304, 300, 299};
    int sy [6] = '{300, 300, 300, 304, 300, 300};
    logic       s_on [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] s_id [6] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0};

    initial begin
        rst_n = 1'b1;
        frame_start = 1'b0;
        applyStimulus(0, 0, 1'b1);
        upd_if.upd_we = 1'b0;   upd_if.upd_idx = '0;  upd_if.upd_px = '0;
        upd_if.upd_py = '0;     upd_if.upd_dir = DIR_EAST;
        upd_if.upd_en = 1'b0;   upd_if.upd_blink = 1'b0;
        upd3_if.upd_we = 1'b0;  upd3_if.upd_idx = '0; upd3_if.upd_px = '0;
        upd3_if.upd_py = '0;    upd3_if.upd_dir = DIR_EAST;
        upd3_if.upd_en = 1'b0;  upd3_if.upd_blink = 1'b0;

        // Reset takes effect before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset", pixel_on, sprite_id, de_out, 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Shape of an east arrow at (100,100); frame counter becomes 1.
        writeSlot(0, 100, 100, DIR_EAST, 1'b1, 1'b0);
        frameStart();
        probe("shape_109_100", 109, 100, 1'b0, 2'd0);
        applyStimulus(108, 100, 1'b1);
        tick();
        checkOutput("latency_1cyc", pixel_on, sprite_id, de_out, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("latency_2cyc_tip", pixel_on, sprite_id, de_out, 1'b1, 2'd0, 1'b1);
        probe("shape_104_104", 104, 104, 1'b1, 2'd0);
        probe("shape_104_105", 104, 105, 1'b0, 2'd0);
        probe("shape_99_100", 99, 100, 1'b0, 2'd0);

        // Double buffering: pending write is invisible until the swap (counter 2).
        writeSlot(0, 200, 50, DIR_NORTH, 1'b1, 1'b0);
        probe("dbuf_old_still", 108, 100, 1'b1, 2'd0);
        frameStart();
        probe("dbuf_north_tip", 200, 42, 1'b1, 2'd0);
        probe("dbuf_old_gone", 108, 100, 1'b0, 2'd0);

        // Write and swap in the same cycle: the swap copies the old pending (counter 3).
        frame_start = 1'b1;
        writeSlot(0, 400, 400, DIR_EAST, 1'b1, 1'b0);
        frame_start = 1'b0;
        probe("wswap_old_used", 200, 42, 1'b1, 2'd0);
        probe("wswap_new_hidden", 400, 400, 1'b0, 2'd0);
        frameStart();
        probe("wswap_new_shown", 400, 400, 1'b1, 2'd0);
        probe("wswap_north_gone", 200, 42, 1'b0, 2'd0);

        // Priority between slots 1 and 3 (counter 1, then 2).
        writeSlot(1, 300, 300, DIR_EAST, 1'b1, 1'b0);
        writeSlot(3, 300, 300, DIR_EAST, 1'b1, 1'b0);
        frameStart();
        probe("prio_low_wins", 302, 300, 1'b1, 2'd1);
        writeSlot(1, 300, 300, DIR_EAST, 1'b0, 1'b0);
        frameStart();
        probe("prio_slot3", 302, 300, 1'b1, 2'd3);

        // Blink: counter MSB set (2,3) hides slot 2, clear (0,1) shows it.
        writeSlot(2, 600, 300, DIR_EAST, 1'b1, 1'b1);
        frameStart();
        probe("blink_cnt3_hidden", 600, 300, 1'b0, 2'd0);
        probe("blink_cnt3_steady", 302, 300, 1'b1, 2'd3);
        frameStart();
        probe("blink_cnt0_shown", 600, 300, 1'b1, 2'd2);
        frameStart();
        probe("blink_cnt1_shown", 600, 300, 1'b1, 2'd2);
        probe("blink_cnt1_steady", 302, 300, 1'b1, 2'd3);
        frameStart();
        probe("blink_cnt2_hidden", 600, 300, 1'b0, 2'd0);
        probe("blink_cnt2_steady", 302, 300, 1'b1, 2'd3);

        // Display enable low on a covered pixel gates the output.
        applyStimulus(302, 300, 1'b0);
        tick();
        tick();
        checkOutput("de_low", pixel_on, sprite_id, de_out, 1'b0, 2'd0, 1'b0);

        // One pixel per cycle: pixel k shows up after edge k+1.
        for (int k = 0; k < 7; k++) begin
            if (k < 6) applyStimulus(sx[k], sy[k], 1'b1);
            tick();
            if (k >= 1)
                checkOutput($sformatf("stream_%0d", k - 1), pixel_on, sprite_id, de_out,
                            s_on[k-1], s_id[k-1], 1'b1);
        end

        // Three-slot build: index 3 must not land anywhere; index 2 is a live control.
        writeSlot3(3, 500, 500, DIR_EAST, 1'b1);
        writeSlot3(2, 700, 700, DIR_EAST, 1'b1);
        frameStart();
        probe3("idx_out_of_range", 500, 500, 1'b0, 2'd0);
        probe3("idx_in_range", 700, 700, 1'b1, 2'd2);

        // Reset mid-frame: outputs clear without a clock and all slots are lost.
        probe("pre_reset_hit", 302, 300, 1'b1, 2'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", pixel_on, sprite_id, de_out, 1'b0, 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        probe("post_reset_lost", 302, 300, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
